// File: rtl/fpu_types_pkg.sv
// Shared half-precision FPU types and constants.
package fpu_types_pkg;
    localparam int unsigned HALF_FLOAT_W    = 16;
    localparam int unsigned FP16_EXP_MAX    = 31;
    localparam int unsigned FP16_BIAS       = 15;
    localparam int unsigned FP16_RAW_EXP_W  = 6;
    localparam int unsigned FP16_RAW_MANT_W = 15;
    // One headroom bit so exp+1 on a right shift and again on a rounding carry never wraps.
    localparam int unsigned FP16_EXT_EXP_W  = FP16_RAW_EXP_W + 1;

    typedef struct packed {
        logic                       sign;
        logic [FP16_EXT_EXP_W-1:0]  exp;
        logic [FP16_RAW_MANT_W-1:0] mant;
    } raw_fp16_t;
endpackage

// File: rtl/fp16_rne_round.sv
// Round-to-nearest-even increment of an extended fp16 mantissa, with carry-out detect.
module fp16_rne_round (
    input  logic [14:0] i_mant,
    output logic [10:0] o_sum,
    output logic        o_carry
);
    logic        w_inc;
    logic [11:0] w_sum;

    always_comb begin
        w_inc = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);
        w_sum = i_mant[14:3] + {11'b0, w_inc};
    end

    assign o_sum   = w_sum[10:0];
    assign o_carry = w_sum[11];
endmodule

// File: rtl/float_norm_round_16bit.sv
// Normalise, round (RNE) and pack one raw adder sum into binary16.
// Define FP16_SUBNORMAL_EN to pack tiny results as subnormals instead of flushing to zero.
module float_norm_round_16bit
    import fpu_types_pkg::*;
#(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned FRAC_W    = 10,
    parameter int unsigned RAW_EXP_W = 6
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    raw_sign,
    input  logic [RAW_EXP_W-1:0]    raw_exp,
    input  logic [14:0]             raw_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HALF_FLOAT_W-1:0] out_sum,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    busy
);
    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    localparam logic [FP16_EXT_EXP_W-1:0] EXP_ONE = FP16_EXT_EXP_W'(1);
    localparam logic [FP16_EXT_EXP_W-1:0] EXP_SAT = FP16_EXT_EXP_W'(FP16_EXP_MAX);

    state_e                    r_state, w_state_nxt;
    raw_fp16_t                 r_op, w_op_nxt;
    logic                      r_tiny, w_tiny_nxt;
    logic [HALF_FLOAT_W-1:0]   r_out_sum, w_sum_nxt;
    logic                      r_ovf, w_ovf_nxt;
    logic                      r_unf, w_unf_nxt;

    logic [10:0]               w_rnd_sum;
    logic                      w_carry;
    logic [FP16_EXT_EXP_W-1:0] w_exp_rnd;
    logic [FRAC_W-1:0]         w_frac;
    logic [HALF_FLOAT_W-1:0]   w_pack_sum;
    logic                      w_pack_ovf;
    logic                      w_pack_unf;

    fp16_rne_round u_round (
        .i_mant  (r_op.mant),
        .o_sum   (w_rnd_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_exp_rnd  = r_op.exp + {{(FP16_EXT_EXP_W-1){1'b0}}, w_carry};
        w_frac     = w_carry ? w_rnd_sum[10:1] : w_rnd_sum[9:0];
        w_pack_ovf = 1'b0;
        w_pack_unf = 1'b0;
        w_pack_sum = {r_op.sign, w_exp_rnd[EXP_W-1:0], w_frac};
        if (r_tiny) begin
            w_pack_unf = 1'b1;
`ifdef FP16_SUBNORMAL_EN
            // Rounding up into the hidden bit yields the smallest normal (exp field 1).
            w_pack_sum = {r_op.sign, {(EXP_W-1){1'b0}}, w_rnd_sum[10], w_frac};
`else
            w_pack_sum = {r_op.sign, {(HALF_FLOAT_W-1){1'b0}}};
`endif
        end else if (w_exp_rnd >= EXP_SAT) begin
            w_pack_ovf = 1'b1;
            w_pack_sum = {r_op.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_tiny_nxt  = r_tiny;
        w_sum_nxt   = r_out_sum;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_op_nxt   = '{sign: raw_sign, exp: {1'b0, raw_exp}, mant: raw_mant};
                    w_tiny_nxt = 1'b0;
                    if (raw_mant == '0) begin
                        w_state_nxt = StDone;
                        w_sum_nxt   = {raw_sign, {(HALF_FLOAT_W-1){1'b0}}};
                        w_ovf_nxt   = 1'b0;
                        w_unf_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = StNorm;
                    end
                end
            end
            StNorm: begin
                if (r_op.mant[14]) begin
                    // Keep the shifted-out bit as sticky so RNE ties stay correct.
                    w_op_nxt.mant = {1'b0, r_op.mant[14:2], r_op.mant[1] | r_op.mant[0]};
                    w_op_nxt.exp  = r_op.exp + EXP_ONE;
                    w_state_nxt   = StRound;
                end else if (r_op.mant[13]) begin
                    w_state_nxt = StRound;
                end else if (r_op.exp > EXP_ONE) begin
                    w_op_nxt.mant = {r_op.mant[13:0], 1'b0};
                    w_op_nxt.exp  = r_op.exp - EXP_ONE;
                end else begin
                    w_tiny_nxt  = 1'b1;
                    w_state_nxt = StRound;
                end
            end
            StRound: begin
                w_sum_nxt   = w_pack_sum;
                w_ovf_nxt   = w_pack_ovf;
                w_unf_nxt   = w_pack_unf;
                w_state_nxt = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= StIdle;
            r_op      <= '0;
            r_tiny    <= 1'b0;
            r_out_sum <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_tiny    <= w_tiny_nxt;
            r_out_sum <= w_sum_nxt;
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
        end
    end

    assign in_ready      = (r_state == StIdle);
    assign busy          = (r_state != StIdle);
    assign out_valid     = (r_state == StDone);
    assign out_sum       = r_out_sum;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;
endmodule

// File: tb/tb_float_norm_round_16bit.sv
// Directed table-driven bench for float_norm_round_16bit, plus backpressure and reset sequences.
module tb_float_norm_round_16bit;
    import fpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        raw_sign;
    logic [5:0]  raw_exp;
    logic [14:0] raw_mant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic        out_underflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    float_norm_round_16bit dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .raw_sign      (raw_sign),
        .raw_exp       (raw_exp),
        .raw_mant      (raw_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        sign;
        logic [5:0]  exp;
        logic [14:0] mant;
        logic [15:0] sum;
        logic        ovf;
        logic        unf;
        logic        chk_flags;
        int          lat;
    } vec_t;

`ifdef FP16_SUBNORMAL_EN
    localparam logic [15:0] TINY_A = 16'h0100;
    localparam logic [15:0] TINY_B = 16'h0400;
`else
    localparam logic [15:0] TINY_A = 16'h0000;
    localparam logic [15:0] TINY_B = 16'h0000;
`endif

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Handshake one operand, then count cycles until out_valid (cycle after handshake = 1).
    task automatic send(input logic s, input logic [5:0] e, input logic [14:0] m, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        raw_sign = s;
        raw_exp  = e;
        raw_mant = m;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int hold;
        logic [15:0] held;

        vecs[0]  = '{1'b0, 6'd15, 15'h4000, 16'h4000, 1'b0, 1'b0, 1'b1, 3};
        vecs[1]  = '{1'b0, 6'd15, 15'h0008, 16'h1400, 1'b0, 1'b0, 1'b1, 13};
        vecs[2]  = '{1'b0, 6'd15, 15'h200C, 16'h3C02, 1'b0, 1'b0, 1'b1, 3};
        vecs[3]  = '{1'b0, 6'd15, 15'h2004, 16'h3C00, 1'b0, 1'b0, 1'b1, 3};
        vecs[4]  = '{1'b0, 6'd30, 15'h4000, 16'h7C00, 1'b1, 1'b0, 1'b1, 3};
        vecs[5]  = '{1'b0, 6'd30, 15'h3FFC, 16'h7C00, 1'b1, 1'b0, 1'b1, 3};
        vecs[6]  = '{1'b0, 6'd1,  15'h0800, TINY_A,   1'b0, 1'b1, 1'b1, 3};
        vecs[7]  = '{1'b1, 6'd15, 15'h2000, 16'hBC00, 1'b0, 1'b0, 1'b1, 3};
        vecs[8]  = '{1'b0, 6'd15, 15'h2006, 16'h3C01, 1'b0, 1'b0, 1'b1, 3};
        vecs[9]  = '{1'b1, 6'd7,  15'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 6'd20, 15'h0400, 16'h4400, 1'b0, 1'b0, 1'b1, 6};
        vecs[11] = '{1'b0, 6'd3,  15'h0800, 16'h0400, 1'b0, 1'b0, 1'b1, 5};
        vecs[12] = '{1'b0, 6'd1,  15'h1FFC, TINY_B,   1'b0, 1'b1, 1'b1, 3};
        vecs[13] = '{1'b0, 6'd15, 15'h4009, 16'h4001, 1'b0, 1'b0, 1'b1, 3};
        vecs[14] = '{1'b1, 6'd62, 15'h4000, 16'hFC00, 1'b1, 1'b0, 1'b1, 3};

        RST       = 1'b1;
        in_valid  = 1'b0;
        raw_sign  = 1'b0;
        raw_exp   = '0;
        raw_mant  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_sum", out_sum, 16'h0000);
        check("reset flags", {out_overflow, out_underflow}, 0);

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].sign, vecs[i].exp, vecs[i].mant, lat);
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d out_sum", i), out_sum, vecs[i].sum);
            if (vecs[i].chk_flags) begin
                check($sformatf("vec%0d overflow", i), out_overflow, vecs[i].ovf);
                check($sformatf("vec%0d underflow", i), out_underflow, vecs[i].unf);
            end
            @(posedge CLK); #1;
        end

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        send(1'b0, 6'd15, 15'h200C, lat);
        check("bp out_valid", out_valid, 1);
        held = out_sum;
        check("bp first sum", held, 16'h3C02);
        // A new operand offered while busy must not be taken.
        raw_sign = 1'b1;
        raw_exp  = 6'd20;
        raw_mant = 15'h4000;
        in_valid = 1'b1;
        for (hold = 0; hold < 5; hold++) begin
            @(posedge CLK); #1;
            check($sformatf("bp hold%0d sum", hold), out_sum, 16'h3C02);
            check($sformatf("bp hold%0d valid", hold), out_valid, 1);
            check($sformatf("bp hold%0d in_ready", hold), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        check("bp release valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);

        // Reset in the middle of a long normalisation discards the job.
        raw_sign = 1'b0;
        raw_exp  = 6'd15;
        raw_mant = 15'h0008;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("mid busy", busy, 1);
        check("mid in_ready", in_ready, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst busy", busy, 0);
        check("rst out_sum", out_sum, 16'h0000);
        repeat (15) @(posedge CLK);
        #1;
        check("rst no late valid", out_valid, 0);

        send(1'b0, 6'd15, 15'h4000, lat);
        check("post-rst latency", lat, 3);
        check("post-rst sum", out_sum, 16'h4000);
        @(posedge CLK); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
